// File: rtl/pixel_scan_pkg.sv
// Shared types and default timing for the display frame-scan sequencer.
package pixel_scan_pkg;

    typedef enum logic [2:0] {IDLE, ARM, ACTIVE, HBLANK, VBLANK} state_t;

    localparam int H_ACTIVE_DEF = 160;
    localparam int H_BLANK_DEF  = 16;
    localparam int V_ACTIVE_DEF = 120;
    localparam int V_BLANK_DEF  = 8;
    localparam int COL_W_DEF    = 8;
    localparam int ROW_W_DEF    = 7;

endpackage

// File: rtl/pixel_scan_ctrl_tick_counter.sv
// Wrapping counter; wraps on the registered terminal flag, so max_val only
// has to describe the range that applies after the current edge.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= (max_val == '0);
        end else if (en) begin
            if (tc) begin
                count <= '0;
                tc    <= (max_val == '0);
            end else begin
                count <= count + W'(1);
                tc    <= ((count + W'(1)) == max_val);
            end
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Frame-scan sequencer: walks a raster on divider ticks, issues per-pixel
// frame-buffer reads over req/ack and produces active-low sync and status.
module pixel_scan_ctrl
    import pixel_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_BLANK  = V_BLANK_DEF,
    parameter int COL_W    = COL_W_DEF,
    parameter int ROW_W    = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic             flag_pulse,
    input  logic             pix_ack,
    output logic             div_enable,
    output logic             pix_req,
    output logic [COL_W-1:0] pix_col,
    output logic [ROW_W-1:0] pix_row,
    output logic             hsync,
    output logic             vsync,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int               H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_AMAX = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_BMAX = ROW_W'(V_BLANK - 1);

    state_t           state;
    logic             tick, scanning, late;
    logic             cnt_clr, col_en, row_en;
    logic [COL_W-1:0] col_cnt;
    logic             col_tc;
    logic [ROW_W-1:0] row_cnt, row_max;
    logic             row_tc;

    assign tick     = flag_pulse;
    assign scanning = (state == ACTIVE) || (state == HBLANK) || (state == VBLANK);
    assign late     = pix_req && !pix_ack;
    assign cnt_clr  = abort || !scanning;
    assign col_en   = tick && scanning;
    assign row_en   = col_en && col_tc;
    // Row range flips between active lines and blank lines exactly when it wraps.
    assign row_max  = ((state == VBLANK) ^ (row_en && row_tc)) ? ROW_BMAX : ROW_AMAX;

    // One column count spans active and blank ticks of a line.
    tick_counter #(.W(COL_W)) u_col_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (cnt_clr),
        .en      (col_en),
        .max_val (COL_MAX),
        .count   (col_cnt),
        .tc      (col_tc)
    );

    tick_counter #(.W(ROW_W)) u_row_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (cnt_clr),
        .en      (row_en),
        .max_val (row_max),
        .count   (row_cnt),
        .tc      (row_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            div_enable <= 1'b0;
            pix_req    <= 1'b0;
            pix_col    <= '0;
            pix_row    <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_ack) pix_req <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                div_enable <= 1'b0;
                busy       <= 1'b0;
                pix_req    <= 1'b0;
                pix_col    <= '0;
                pix_row    <= '0;
                hsync      <= 1'b1;
                vsync      <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state      <= ARM;
                        div_enable <= 1'b1;
                        busy       <= 1'b1;
                        underrun   <= 1'b0;
                    end
                    ARM: if (tick) begin
                        state   <= ACTIVE;
                        pix_req <= 1'b1;
                        pix_col <= '0;
                        pix_row <= '0;
                    end
                    ACTIVE: if (tick) begin
                        if (late) underrun <= 1'b1;
                        if (col_cnt == COL_LAST) begin
                            state <= HBLANK;
                            hsync <= 1'b0;
                        end else begin
                            pix_req <= 1'b1;
                            pix_col <= col_cnt + COL_W'(1);
                        end
                    end
                    HBLANK: if (tick && col_tc) begin
                        hsync <= 1'b1;
                        if (row_tc) begin
                            state <= VBLANK;
                            vsync <= 1'b0;
                        end else begin
                            state   <= ACTIVE;
                            pix_req <= 1'b1;
                            pix_col <= '0;
                            pix_row <= row_cnt + ROW_W'(1);
                            if (late) underrun <= 1'b1;
                        end
                    end
                    VBLANK: if (tick) begin
                        if (col_tc && row_tc) begin
                            hsync      <= 1'b1;
                            vsync      <= 1'b1;
                            frame_done <= 1'b1;
                            if (continuous) begin
                                state   <= ACTIVE;
                                pix_req <= 1'b1;
                                pix_col <= '0;
                                pix_row <= '0;
                                if (late) underrun <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                div_enable <= 1'b0;
                                busy       <= 1'b0;
                            end
                        end else begin
                            // Low once the next column lands in the blank part of the line.
                            hsync <= col_tc || (col_cnt < COL_LAST);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Scenario bench for pixel_scan_ctrl on a tiny 4x3 raster, checked against a
// raster-position model derived from the tick index.
module tb_pixel_scan_ctrl;

    localparam int HA = 4, HB = 2, VA = 3, VB = 1, CW = 3, RW = 2;
    localparam int HT    = HA + HB;
    localparam int FRAME = (VA + VB) * HT;
    localparam int WT    = 1 * HT + 2;   // tick index that requests pixel (2,1)

    typedef struct { logic req; logic hs; logic vs; logic fd; int col; int row; } exp_t;

    logic clk = 1'b0, n_rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, continuous = 1'b0, flag_pulse = 1'b0;
    logic pix_ack, withhold = 1'b0;
    logic div_enable, pix_req, hsync, vsync, busy, frame_done, underrun;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    pixel_scan_ctrl #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                      .COL_W(CW), .ROW_W(RW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .continuous(continuous),
        .flag_pulse(flag_pulse), .pix_ack(pix_ack), .div_enable(div_enable),
        .pix_req(pix_req), .pix_col(pix_col), .pix_row(pix_row), .hsync(hsync),
        .vsync(vsync), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    assign pix_ack = pix_req && !(withhold && pix_col == CW'(2) && pix_row == RW'(1));

    // Tick t after the arming tick sits at raster position t mod FRAME.
    function automatic exp_t model(input int t, input bit cont);
        exp_t e;
        int f, ln, x;
        f = t % FRAME;
        ln = f / HT;
        x = f % HT;
        e.fd  = (t > 0) && (f == 0);
        e.req = !(e.fd && !cont) && (ln < VA) && (x < HA);
        e.col = x;
        e.row = ln;
        e.hs  = (x < HA);
        e.vs  = (ln < VA);
        return e;
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Tick edge lands gap cycles after the previous one; ra = pix_req one cycle after it.
    task automatic pulse_tick(input int gap, input bit poke, output logic ra, output logic fg);
        @(posedge clk); #1 ra = pix_req; fg = frame_done; start = poke;
        repeat (gap - 2) begin @(posedge clk); #1 fg |= frame_done; start = 1'b0; end
        flag_pulse = 1'b1;
        @(posedge clk); #1 flag_pulse = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; #12;
        n_checks++;
        if ({div_enable, pix_req, pix_col, pix_row, hsync, vsync, busy, frame_done, underrun} !==
            {1'b0, 1'b0, CW'(0), RW'(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL reset outputs got %b", {div_enable, pix_req, pix_col, pix_row, hsync, vsync, busy, frame_done, underrun}); end
        @(negedge clk) n_rst = 1'b1;
    endtask

    task automatic test_single_frame();
        exp_t e; logic ra, fg;
        continuous = 1'b0;
        do_start();
        n_checks++;
        if ({busy, div_enable, pix_req} !== 3'b110) begin n_fail++; $display("FAIL arm busy/div/req got %b want 110", {busy, div_enable, pix_req}); end
        for (int t = 0; t <= FRAME; t++) begin
            pulse_tick(8, 1'b0, ra, fg);
            e = model(t, 1'b0);
            n_checks++;
            if ({pix_req, hsync, vsync, frame_done} !== {e.req, e.hs, e.vs, e.fd}) begin n_fail++;
                $display("FAIL frame t=%0d req/hs/vs/fd got %b want %b", t, {pix_req, hsync, vsync, frame_done}, {e.req, e.hs, e.vs, e.fd}); end
            if (e.req) begin n_checks++;
                if (pix_col !== CW'(e.col) || pix_row !== RW'(e.row)) begin n_fail++;
                    $display("FAIL frame t=%0d addr got (%0d,%0d) want (%0d,%0d)", t, pix_col, pix_row, e.col, e.row); end end
            if (t > 0) begin n_checks++;
                if ({ra, fg} !== 2'b00) begin n_fail++; $display("FAIL frame t=%0d req_drop/gap_fd got %b want 00", t, {ra, fg}); end end
        end
        @(posedge clk); #1;
        n_checks++;
        if ({div_enable, busy, underrun, frame_done} !== 4'b0000) begin n_fail++;
            $display("FAIL frame_end div/busy/underrun/fd got %b want 0000", {div_enable, busy, underrun, frame_done}); end
    endtask

    task automatic test_underrun();
        exp_t e; logic ra, fg;
        withhold = 1'b1;
        do_start();
        for (int t = 0; t <= FRAME; t++) begin
            pulse_tick(int'($urandom_range(2, 9)), 1'b0, ra, fg);
            e = model(t, 1'b0);
            n_checks++;
            if ({pix_req, hsync, vsync, frame_done} !== {e.req, e.hs, e.vs, e.fd}) begin n_fail++;
                $display("FAIL underrun t=%0d req/hs/vs/fd got %b want %b", t, {pix_req, hsync, vsync, frame_done}, {e.req, e.hs, e.vs, e.fd}); end
            if (e.req) begin n_checks++;
                if (pix_col !== CW'(e.col) || pix_row !== RW'(e.row)) begin n_fail++;
                    $display("FAIL underrun t=%0d addr got (%0d,%0d) want (%0d,%0d)", t, pix_col, pix_row, e.col, e.row); end end
            n_checks++;
            if (underrun !== 1'(t > WT)) begin n_fail++; $display("FAIL underrun t=%0d flag got %b want %b", t, underrun, t > WT); end
            if (t > 0) begin n_checks++;
                if (ra !== 1'(t == WT + 1)) begin n_fail++; $display("FAIL underrun t=%0d held_req got %b want %b", t, ra, t == WT + 1); end end
        end
        withhold = 1'b0;
    endtask

    task automatic test_start();
        exp_t e; logic ra, fg;
        n_checks++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL start_pre underrun got %b want 1", underrun); end
        do_start();
        n_checks++;
        if ({underrun, busy, div_enable} !== 3'b011) begin n_fail++; $display("FAIL start_clear un/busy/div got %b want 011", {underrun, busy, div_enable}); end
        for (int t = 0; t <= FRAME; t++) begin
            pulse_tick(int'($urandom_range(2, 9)), 1'b1, ra, fg);
            e = model(t, 1'b0);
            n_checks++;
            if ({pix_req, hsync, vsync, frame_done} !== {e.req, e.hs, e.vs, e.fd}) begin n_fail++;
                $display("FAIL start_ignored t=%0d req/hs/vs/fd got %b want %b", t, {pix_req, hsync, vsync, frame_done}, {e.req, e.hs, e.vs, e.fd}); end
            if (e.req) begin n_checks++;
                if (pix_col !== CW'(e.col) || pix_row !== RW'(e.row)) begin n_fail++;
                    $display("FAIL start_ignored t=%0d addr got (%0d,%0d) want (%0d,%0d)", t, pix_col, pix_row, e.col, e.row); end end
        end
    endtask

    task automatic test_continuous();
        exp_t e; logic ra, fg;
        continuous = 1'b1;
        do_start();
        for (int t = 0; t <= FRAME + HT; t++) begin
            pulse_tick(int'($urandom_range(2, 9)), 1'b0, ra, fg);
            e = model(t, 1'b1);
            n_checks++;
            if ({pix_req, hsync, vsync, frame_done, busy} !== {e.req, e.hs, e.vs, e.fd, 1'b1}) begin n_fail++;
                $display("FAIL cont t=%0d req/hs/vs/fd/busy got %b want %b", t, {pix_req, hsync, vsync, frame_done, busy}, {e.req, e.hs, e.vs, e.fd, 1'b1}); end
            if (e.req) begin n_checks++;
                if (pix_col !== CW'(e.col) || pix_row !== RW'(e.row)) begin n_fail++;
                    $display("FAIL cont t=%0d addr got (%0d,%0d) want (%0d,%0d)", t, pix_col, pix_row, e.col, e.row); end end
        end
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; continuous = 1'b0;
        n_checks++;
        if ({busy, div_enable} !== 2'b00) begin n_fail++; $display("FAIL cont_abort busy/div got %b want 00", {busy, div_enable}); end
    endtask

    task automatic test_abort();
        logic ra, fg;
        do_start();
        for (int t = 0; t <= HT + HA; t++) pulse_tick(int'($urandom_range(2, 9)), 1'b0, ra, fg);
        n_checks++;
        if ({hsync, vsync} !== 2'b01) begin n_fail++; $display("FAIL abort_pre hs/vs got %b want 01", {hsync, vsync}); end
        @(negedge clk); abort = 1'b1; flag_pulse = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; flag_pulse = 1'b0; start = 1'b0;
        n_checks++;
        if ({div_enable, pix_req, hsync, vsync, busy, frame_done, pix_col, pix_row} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CW'(0), RW'(0)}) begin n_fail++;
            $display("FAIL abort outputs got %b", {div_enable, pix_req, hsync, vsync, busy, frame_done, pix_col, pix_row}); end
        for (int i = 0; i < 3; i++) begin
            pulse_tick(5, 1'b0, ra, fg);
            n_checks++;
            if ({pix_req, busy, div_enable, frame_done, fg} !== 5'b00000) begin n_fail++;
                $display("FAIL abort_idle i=%0d req/busy/div/fd/gap_fd got %b want 00000", i, {pix_req, busy, div_enable, frame_done, fg}); end
        end
    endtask

    task automatic test_async_reset();
        logic ra, fg;
        do_start();
        for (int t = 0; t <= VA * HT + 2; t++) pulse_tick(int'($urandom_range(2, 9)), 1'b0, ra, fg);
        n_checks++;
        if ({vsync, busy} !== 2'b01) begin n_fail++; $display("FAIL areset_pre vs/busy got %b want 01", {vsync, busy}); end
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({div_enable, pix_req, pix_col, pix_row, hsync, vsync, busy, frame_done, underrun} !==
            {1'b0, 1'b0, CW'(0), RW'(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL areset outputs got %b", {div_enable, pix_req, pix_col, pix_row, hsync, vsync, busy, frame_done, underrun}); end
        @(negedge clk) n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_start();
        test_continuous();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_scan_ctrl.md
Name: pixel_scan_ctrl

Overview:
Frame-scan sequencer for the display pixel path.
- Gates the pixel clock divider through `div_enable`.
- Consumes the divider's one-cycle `flag_pulse` strobe ("tick").
- Walks row/column positions and issues per-pixel read requests to the frame buffer with a req/ack handshake.
- Generates active-low hsync/vsync and frame-completion status for the output stage.

Parameters:
H_ACTIVE, 160, visible pixels per line
H_BLANK, 16, blanking ticks per line
V_ACTIVE, 120, visible lines per frame
V_BLANK, 8, blanking lines per frame (each H_ACTIVE+H_BLANK ticks)
COL_W, 8, column/blank counter width, must hold H_ACTIVE+H_BLANK-1
ROW_W, 7, row counter width, must hold max(V_ACTIVE,V_BLANK)-1

Ports:
clk  in  1  system clock
n_rst  in  1  reset; asynchronous, active-low
start  in  1  one-cycle request to begin scanning
abort  in  1  stop immediately, return to idle
continuous  in  1  sampled at frame end; 1 = rescan without returning to idle
flag_pulse  in  1  tick strobe from pixel clock divider
pix_ack  in  1  frame buffer accepted current request
div_enable  out  1  enable to clock divider
pix_req  out  1  pixel read request, held until ack
pix_col  out  COL_W  column of current request
pix_row  out  ROW_W  row of current request
hsync  out  1  active-low, low during HBLANK ticks
vsync  out  1  active-low, low during VBLANK
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of each frame
underrun  out  1  sticky; tick arrived with request unacknowledged

Behaviour:
- All outputs are registered.
- Reset values: div_enable=0, pix_req=0, pix_col=0, pix_row=0, hsync=1, vsync=1, busy=0, frame_done=0, underrun=0, state=IDLE.
- States and transitions:
  - IDLE: start=1 -> ARM; div_enable=1 and busy=1 from the next cycle.
  - ARM: wait for a tick. On tick -> ACTIVE, with pix_req=1 and col=0, row=0 registered the same edge. The first request is visible 1 cycle after the tick.
  - ACTIVE: each tick:
    - col<H_ACTIVE-1: col++ and a new request.
    - col=H_ACTIVE-1: -> HBLANK, blank count=0, hsync=0.
  - HBLANK: counts H_BLANK ticks. On the last one hsync=1, then:
    - row<V_ACTIVE-1: row++, col=0, -> ACTIVE with a request.
    - row=V_ACTIVE-1: -> VBLANK, vsync=0, line=0, col=0.
  - VBLANK: col counts 0..H_ACTIVE+H_BLANK-1 per line. hsync=0 when col>=H_ACTIVE. Line counts 0..V_BLANK-1. On the last tick of the last line: vsync=1 and frame_done pulses 1 cycle, then:
    - continuous=1: -> ACTIVE at (0,0) with a request.
    - otherwise: -> IDLE, div_enable=0 and busy=0 from the next cycle.
- Handshake:
  - pix_req stays high until a cycle with pix_ack=1. It drops the following cycle unless a tick in that same cycle loads a new request.
  - pix_col/pix_row are stable while pix_req=1.
  - pix_ack with pix_req=0 is ignored.
- Underrun:
  - Condition: a tick in ACTIVE (including the new-request edge from HBLANK/VBLANK) while pix_req=1 and pix_ack=0.
  - Effect: underrun is set. The request is retargeted to the new address and stays high; the scan never stalls.
  - Clearing: only by reset or a new start in IDLE.
- Ticks outside ARM/ACTIVE/HBLANK/VBLANK are ignored.
- Abort, any state: next cycle state=IDLE, div_enable=0, pix_req=0, hsync=vsync=1, counters=0, no frame_done pulse. Abort has priority over start and tick.
- start outside IDLE is ignored.
- Asynchronous reset mid-frame forces the reset values immediately.
- Counters are modulo by explicit compare, never by natural width overflow.

Decomposition:
- Shared package pixel_scan_pkg:
  - state typedef enum {IDLE, ARM, ACTIVE, HBLANK, VBLANK}.
  - Default timing constants.
  - COL_W/ROW_W.
- One natural sub-module, tick_counter: a wrapping counter with enable, clear, MAX input, and a registered terminal-count flag. Instantiated for column/blank and for row/line counting.

Test Plan:
- Parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, ack same cycle as req; tick every 8 clk; start, continuous=0:
  - 12 requests (0,0)..(3,2) in order.
  - hsync low for 2 ticks after each line.
  - vsync low for 6 ticks.
  - frame_done pulses once.
  - div_enable=0 one cycle after frame_done; underrun=0.
- Same setup with ack withheld on pixel (2,1): underrun=1 after the next tick; pix_col/pix_row advance to (3,1); scan completes on time.
- continuous=1: after frame_done, the next request is (0,0) exactly 1 cycle after the following tick; busy stays 1.
- abort asserted during HBLANK of row 1: next cycle state IDLE, pix_req=0, div_enable=0, hsync=vsync=1, no frame_done.
- start pulsed while ACTIVE: no effect on counters or outputs; start in IDLE with underrun=1: underrun cleared.
- n_rst low mid-VBLANK: all outputs at reset values immediately, without a clk edge.
